// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit CPU: opcodes, funct codes, field slices,
// sequencer state encoding and the decoded-instruction bundle.
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LB    = 4'h2;
    localparam logic [3:0] OP_SB    = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_ANDI  = 4'h6;
    localparam logic [3:0] OP_RTYPE = 4'hF;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_SRL = 3'b011;
    localparam logic [2:0] FN_AND = 3'b101;
    localparam logic [2:0] FN_OR  = 3'b110;

    localparam int OP_HI    = 15, OP_LO    = 12;
    localparam int RS_HI    = 11, RS_LO    = 9;
    localparam int RT_HI    = 8,  RT_LO    = 6;
    localparam int RD_HI    = 5,  RD_LO    = 3;
    localparam int FUNCT_HI = 2,  FUNCT_LO = 0;
    localparam int IMM6_HI  = 5,  IMM6_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       is_nop;
        logic       is_ld;
        logic       is_st;
        logic       is_alu;
        logic       use_imm;
        logic       imm_signed;
        logic       illegal;
        logic [2:0] wa;
        logic [2:0] alu_func;
    } decode_t;

    function automatic logic [7:0] extend_imm6(input logic [5:0] imm6, input logic is_signed);
        return is_signed ? {{2{imm6[5]}}, imm6} : {2'b00, imm6};
    endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder: classifies the latched instruction word and
// derives the write index and ALU function for the sequencer.
module cpu_instr_decode
    import cpu_isa_pkg::*;
(
    input  logic [15:0] ir,
    output decode_t     dec
);

    logic [3:0] opcode;
    assign opcode = ir[OP_HI:OP_LO];

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch.
        dec            = '0;
        dec.wa         = ir[RT_HI:RT_LO];
        dec.alu_func   = FN_ADD;
        dec.imm_signed = 1'b1;
        unique case (opcode)
            OP_NOP: dec.is_nop = 1'b1;
            OP_LB: begin
                dec.is_ld   = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_SB: begin
                dec.is_st   = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_ADDI: begin
                dec.is_alu  = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_ANDI: begin
                dec.is_alu     = 1'b1;
                dec.use_imm    = 1'b1;
                dec.imm_signed = 1'b0;
                dec.alu_func   = FN_AND;
            end
            OP_RTYPE: begin
                // Funct is passed straight to the ALU; unknown codes are not trapped.
                dec.is_alu   = 1'b1;
                dec.wa       = ir[RD_HI:RD_LO];
                dec.alu_func = ir[FUNCT_HI:FUNCT_LO];
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Multi-cycle control sequencer: owns PC, IR, phase FSM and the sticky illegal flag,
// and issues per-phase control to the register file, ALU, data memory and writeback.
module cpu_ctrl_sequencer
    import cpu_isa_pkg::*;
#(
    parameter logic [7:0] HALT_ADDR = 8'hFE,
    parameter logic [7:0] RESET_PC  = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic [7:0]  PC_ADDR,
    input  logic [15:0] INSTR,
    output logic [2:0]  RF_RA1,
    output logic [2:0]  RF_RA2,
    output logic [2:0]  RF_WA,
    output logic        RF_WE,
    output logic [2:0]  ALU_FUNC,
    output logic        ALU_SRC_IMM,
    output logic [7:0]  IMM,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    input  logic        DMEM_READY,
    output logic        WB_SEL,
    output logic        BUSY,
    output logic        HALTED,
    output logic        ILLEGAL
);

    state_t     state, state_d;
    logic [7:0] pc, pc_d;
    logic [15:0] ir, ir_d;
    logic       illegal_q, illegal_d;
    decode_t    dec;

    cpu_instr_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    // NOTE: sequential state uses non-blocking assignments only; the next-state
    // values come from the combinational block below.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        ir_d      = ir;
        illegal_d = illegal_q;
        unique case (state)
            ST_IDLE, ST_HALT: begin
                if (START) begin
                    state_d   = ST_FETCH;
                    pc_d      = RESET_PC;
                    illegal_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (pc == HALT_ADDR) begin
                    state_d = ST_HALT;
                end else begin
                    ir_d    = INSTR;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                pc_d = pc + 8'd2;
                if (dec.illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (dec.is_nop) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = (dec.is_ld || dec.is_st) ? ST_MEM : ST_WB;
            ST_MEM: begin
                // Request is held until the memory completes; loads still need WB.
                if (DMEM_READY) state_d = dec.is_ld ? ST_WB : ST_FETCH;
            end
            ST_WB:    state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign PC_ADDR     = pc;
    assign RF_RA1      = ir[RS_HI:RS_LO];
    assign RF_RA2      = ir[RT_HI:RT_LO];
    assign RF_WA       = dec.wa;
    assign ALU_FUNC    = dec.alu_func;
    assign ALU_SRC_IMM = dec.use_imm;
    assign IMM         = extend_imm6(ir[IMM6_HI:IMM6_LO], dec.imm_signed);
    assign WB_SEL      = dec.is_ld;

    assign RF_WE    = (state == ST_WB);
    assign DMEM_REQ = (state == ST_MEM);
    assign DMEM_WE  = (state == ST_MEM) && dec.is_st;
    assign BUSY     = (state != ST_IDLE) && (state != ST_HALT);
    assign HALTED   = (state == ST_HALT);
    assign ILLEGAL  = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Directed bench for cpu_ctrl_sequencer: a behavioural ROM feeds hand-built programs
// and each phase's control outputs are compared against hand-computed values.
module tb_cpu_ctrl_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, START, DMEM_READY;
    logic [7:0]  PC_ADDR, IMM;
    logic [15:0] INSTR;
    logic [2:0]  RF_RA1, RF_RA2, RF_WA, ALU_FUNC;
    logic        RF_WE, ALU_SRC_IMM, DMEM_REQ, DMEM_WE, WB_SEL, BUSY, HALTED, ILLEGAL;

    logic [15:0] rom [128];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          req_cycles;
    int          total_cycles;

    always #5 CLK = ~CLK;

    assign INSTR = rom[PC_ADDR[7:1]];

    cpu_ctrl_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .PC_ADDR     (PC_ADDR),
        .INSTR       (INSTR),
        .RF_RA1      (RF_RA1),
        .RF_RA2      (RF_RA2),
        .RF_WA       (RF_WA),
        .RF_WE       (RF_WE),
        .ALU_FUNC    (ALU_FUNC),
        .ALU_SRC_IMM (ALU_SRC_IMM),
        .IMM         (IMM),
        .DMEM_REQ    (DMEM_REQ),
        .DMEM_WE     (DMEM_WE),
        .DMEM_READY  (DMEM_READY),
        .WB_SEL      (WB_SEL),
        .BUSY        (BUSY),
        .HALTED      (HALTED),
        .ILLEGAL     (ILLEGAL)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        RESET = 1'b1; START = 1'b0; DMEM_READY = 1'b0;
        step();
        step();
        check("rst_pc",      PC_ADDR,  16'h00);
        check("rst_busy",    BUSY,     16'h0);
        check("rst_halted",  HALTED,   16'h0);
        check("rst_illegal", ILLEGAL,  16'h0);
        check("rst_rfwe",    RF_WE,    16'h0);
        check("rst_req",     DMEM_REQ, 16'h0);

        // Program 1: SUB R0,R0,R0 ; ADDI R5,R0,-1 ; illegal opcode 0x3 at 0x04
        rom[0] = 16'hF001; rom[1] = 16'h517F; rom[2] = 16'h3000;
        RESET = 1'b0; START = 1'b1;
        step();                                   // FETCH
        START = 1'b0;
        check("sub_fetch_pc", PC_ADDR, 16'h00);
        check("sub_busy",     BUSY,    16'h1);
        step();                                   // DECODE
        step();                                   // EXEC
        check("sub_func",     ALU_FUNC, 16'h1);
        check("sub_exec_we",  RF_WE,    16'h0);
        step();                                   // WB, cycle 4
        check("sub_wb_we",    RF_WE,    16'h1);
        check("sub_wb_wa",    RF_WA,    16'h0);
        check("sub_wb_sel",   WB_SEL,   16'h0);
        step();                                   // FETCH
        check("addi_fetch_pc", PC_ADDR, 16'h02);
        check("addi_fetch_we", RF_WE,   16'h0);
        step();                                   // DECODE
        check("addi_imm",     IMM,         16'hFF);
        check("addi_srcimm",  ALU_SRC_IMM, 16'h1);
        check("addi_wa",      RF_WA,       16'h5);
        check("addi_ra1",     RF_RA1,      16'h0);
        check("addi_func",    ALU_FUNC,    16'h0);
        step();                                   // EXEC
        step();                                   // WB
        check("addi_wb_we",   RF_WE,   16'h1);
        step();                                   // FETCH
        check("ill_fetch_pc", PC_ADDR, 16'h04);
        step();                                   // DECODE
        step();                                   // HALT
        check("ill_halted",   HALTED,  16'h1);
        check("ill_flag",     ILLEGAL, 16'h1);
        check("ill_pc",       PC_ADDR, 16'h06);
        check("ill_busy",     BUSY,    16'h0);
        step();
        check("ill_pc_hold",  PC_ADDR, 16'h06);
        check("ill_sticky",   ILLEGAL, 16'h1);

        // Program 2: ANDI R5,R7,1 ; LB R1,-6(R5) ; SB R7,-8(R5) ; NOPs to HALT_ADDR
        rom[0] = 16'h6F41; rom[1] = 16'h2A7A; rom[2] = 16'h4BF8;
        START = 1'b1;
        step();                                   // FETCH
        START = 1'b0;
        check("restart_pc",      PC_ADDR, 16'h00);
        check("restart_illegal", ILLEGAL, 16'h0);
        check("restart_halted",  HALTED,  16'h0);
        step();                                   // DECODE
        check("andi_imm",    IMM,         16'h01);
        check("andi_func",   ALU_FUNC,    16'h5);
        check("andi_srcimm", ALU_SRC_IMM, 16'h1);
        check("andi_wa",     RF_WA,       16'h5);
        check("andi_ra1",    RF_RA1,      16'h7);
        step();                                   // EXEC
        step();                                   // WB
        check("andi_wb_we",  RF_WE,   16'h1);
        step();                                   // FETCH of LB
        check("lb_fetch_pc", PC_ADDR, 16'h02);
        req_cycles = 0;
        total_cycles = 1;
        step(); total_cycles++;                   // DECODE
        check("lb_imm",      IMM,      16'hFA);
        check("lb_func",     ALU_FUNC, 16'h0);
        step(); total_cycles++;                   // EXEC
        step(); total_cycles++;                   // MEM, first cycle
        for (int i = 0; i < 3; i++) begin
            if (DMEM_REQ) req_cycles++;
            check("lb_wait_req", DMEM_REQ, 16'h1);
            check("lb_wait_we",  DMEM_WE,  16'h0);
            step(); total_cycles++;
        end
        DMEM_READY = 1'b1;
        if (DMEM_REQ) req_cycles++;
        check("lb_ready_req", DMEM_REQ, 16'h1);
        step(); total_cycles++;                   // WB
        DMEM_READY = 1'b0;
        check("lb_req_cycles", 16'(req_cycles), 16'd4);
        check("lb_total",      16'(total_cycles), 16'd8);
        check("lb_wb_we",      RF_WE,    16'h1);
        check("lb_wb_sel",     WB_SEL,   16'h1);
        check("lb_wb_wa",      RF_WA,    16'h1);
        check("lb_wb_req",     DMEM_REQ, 16'h0);
        step();                                   // FETCH of SB
        check("sb_fetch_pc",   PC_ADDR,  16'h04);
        step();                                   // DECODE
        check("sb_imm",        IMM,      16'hF8);
        check("sb_ra2",        RF_RA2,   16'h7);
        START = 1'b1;                             // ignored while busy
        step();                                   // EXEC
        START = 1'b0;
        check("busy_start_pc", PC_ADDR,  16'h06);
        check("sb_exec_we",    RF_WE,    16'h0);
        step();                                   // MEM
        DMEM_READY = 1'b1;
        check("sb_req",        DMEM_REQ, 16'h1);
        check("sb_dwe",        DMEM_WE,  16'h1);
        check("sb_mem_rfwe",   RF_WE,    16'h0);
        step();                                   // back to FETCH
        DMEM_READY = 1'b0;
        check("sb_after_pc",   PC_ADDR,  16'h06);
        check("sb_after_rfwe", RF_WE,    16'h0);
        check("sb_after_req",  DMEM_REQ, 16'h0);
        check("sb_after_busy", BUSY,     16'h1);

        for (int i = 0; i < 400 && !HALTED; i++) step();
        check("nop_halted",  HALTED,  16'h1);
        check("nop_halt_pc", PC_ADDR, 16'hFE);
        check("nop_illegal", ILLEGAL, 16'h0);

        // Reset while a load waits in MEM
        rom[0] = 16'h2A7A;
        START = 1'b1;
        step();                                   // FETCH
        START = 1'b0;
        step();                                   // DECODE
        step();                                   // EXEC
        step();                                   // MEM
        step();                                   // MEM, still waiting
        check("rstmem_req", DMEM_REQ, 16'h1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rstmem_req_after",  DMEM_REQ, 16'h0);
        check("rstmem_busy_after", BUSY,     16'h0);
        check("rstmem_rfwe_after", RF_WE,    16'h0);
        check("rstmem_pc_after",   PC_ADDR,  16'h00);
        step();
        check("rstmem_idle_stays", BUSY,     16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
